// File: rtl/mem_responder.sv
// mem_responder: single-port word memory answering the core CEN/WEN/OEN interface,
// with a bulk-load port and a dump port arbitrated by a mode FSM.
module mem_responder #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              wen,
  input  logic              oen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              dp_start,
  input  logic [ADDR_W-1:0] dp_base,
  input  logic [ADDR_W:0]   dp_count,
  output logic              dp_valid,
  output logic [DATA_W-1:0] dp_data,
  input  logic              dp_ready,
  output logic              busy
);
  typedef enum logic [1:0] {RUN, LOAD, DRD, DOUT} state_e;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
  state_e            state_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dp_data_q;
  logic              dp_valid_q;
  logic              ld_ready_q;
  logic              busy_q;
  logic              core_en;
  logic              ld_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_d;
  always_comb begin
    core_en = state_q == RUN && !cen;
    ld_acc  = state_q == LOAD && ld_valid && ld_ready_q;
    mem_we  = !rst && (ld_acc || (core_en && wen));
    mem_a   = ld_acc ? ptr_q : addr;
    mem_d   = ld_acc ? ld_data : datain;
  end
  // array has no reset so preloaded contents survive a core reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      ptr_q      <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
      dp_data_q  <= '0;
      dp_valid_q <= 1'b0;
      ld_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (core_en && !wen) dout_q <= mem[addr];
          if (ld_start) begin
            state_q    <= LOAD;
            ptr_q      <= ld_base;
            cnt_q      <= '0;
            ld_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end else if (dp_start && dp_count != '0) begin
            state_q <= DRD;
            ptr_q   <= dp_base;
            cnt_q   <= dp_count;
            busy_q  <= 1'b1;
          end
        end
        LOAD: if (ld_acc) begin
          ptr_q <= ptr_q + 1'b1;
          cnt_q <= cnt_q + 1'b1;
          if (ld_last || cnt_q == LAST) begin
            state_q    <= RUN;
            ld_ready_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        DRD: begin
          dp_data_q  <= mem[ptr_q];
          dp_valid_q <= 1'b1;
          state_q    <= DOUT;
        end
        default: if (dp_ready) begin
          dp_valid_q <= 1'b0;
          ptr_q      <= ptr_q + 1'b1;
          cnt_q      <= cnt_q - 1'b1;
          state_q    <= cnt_q == ONE ? RUN : DRD;
          busy_q     <= cnt_q != ONE;
        end
      endcase
    end
  end
  assign dataout  = (oen || state_q != RUN) ? '0 : dout_q;
  assign ld_ready = ld_ready_q;
  assign dp_valid = dp_valid_q;
  assign dp_data  = dp_data_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed stimulus with a queue scoreboard for core reads and dump words.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b1;
  logic        wen = 1'b0;
  logic        oen = 1'b0;
  logic [10:0] addr = '0;
  logic [31:0] datain = '0;
  logic [31:0] dataout;
  logic        ld_start = 1'b0;
  logic [10:0] ld_base = '0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        dp_start = 1'b0;
  logic [10:0] dp_base = '0;
  logic [11:0] dp_count = '0;
  logic        dp_valid;
  logic [31:0] dp_data;
  logic        dp_ready = 1'b0;
  logic        busy;
  logic        rd_req = 1'b0;
  logic        rd_pend = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rd[$];
  logic [31:0] exp_dp[$];

  mem_responder dut (
    .clk(clk), .rst(rst), .cen(cen), .wen(wen), .oen(oen), .addr(addr),
    .datain(datain), .dataout(dataout), .ld_start(ld_start), .ld_base(ld_base),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .dp_start(dp_start), .dp_base(dp_base), .dp_count(dp_count), .dp_valid(dp_valid),
    .dp_data(dp_data), .dp_ready(dp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d);
    cen = 1'b0; wen = 1'b1; addr = a; datain = d;
    cyc();
    cen = 1'b1; wen = 1'b0;
  endtask

  task automatic rd(input logic [10:0] a, input logic [31:0] e);
    cen = 1'b0; wen = 1'b0; addr = a; rd_req = 1'b1;
    exp_rd.push_back(e);
    cyc();
    cen = 1'b1; rd_req = 1'b0;
  endtask

  always @(posedge clk) rd_pend <= rd_req;

  // monitor: pops expectations whenever the DUT presents a read result or dump word
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_rd.size() == 0) chk("core_rd_unexpected", dataout, 32'hx);
      else chk("core_rd", dataout, exp_rd.pop_front());
    end
    if (dp_valid && dp_ready) begin
      if (exp_dp.size() == 0) chk("dump_unexpected", dp_data, 32'hx);
      else chk("dump_word", dp_data, exp_dp.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc(2);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_dp_valid", 32'(dp_valid), 0);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    // core write then read, then oen forcing
    wr(11'h005, 32'hDEADBEEF);
    rd(11'h005, 32'hDEADBEEF);
    @(negedge clk); #1;
    oen = 1'b1; #1;
    chk("oen_force_zero", dataout, 0);
    oen = 1'b0; #1;
    chk("oen_release", dataout, 32'hDEADBEEF);
    // back-to-back write/read and idle hold
    wr(11'h7FF, 32'h11);
    rd(11'h7FF, 32'h11);
    cyc(3);
    chk("idle_hold", dataout, 32'h11);
    // gapped load with wrap and last
    ld_start = 1'b1; ld_base = 11'h7FE;
    cyc();
    ld_start = 1'b0;
    chk("load_busy", 32'(busy), 1);
    chk("load_ready", 32'(ld_ready), 1);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b0;
      cyc();
      ld_valid = 1'b1; ld_data = 32'hA + 32'(i); ld_last = (i == 2);
      cyc();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("load_done_busy", 32'(busy), 0);
    chk("load_done_ready", 32'(ld_ready), 0);
    rd(11'h7FE, 32'hA);
    rd(11'h7FF, 32'hB);
    rd(11'h000, 32'hC);
    // dump with backpressure on the first word
    dp_start = 1'b1; dp_base = 11'h7FE; dp_count = 12'd3; dp_ready = 1'b0;
    exp_dp.push_back(32'hA); exp_dp.push_back(32'hB); exp_dp.push_back(32'hC);
    cyc();
    dp_start = 1'b0;
    chk("dump_busy", 32'(busy), 1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("dump_hold_valid", 32'(dp_valid), 1);
      chk("dump_hold_data", dp_data, 32'hA);
      cyc();
    end
    dp_ready = 1'b1;
    for (int n = 0; n < 20 && busy; n++) cyc();
    chk("dump_done_busy", 32'(busy), 0);
    chk("dump_queue_empty", 32'(exp_dp.size()), 0);
    dp_ready = 1'b0;
    // arbitration: LOAD wins, dp_start and core ignored during LOAD
    ld_start = 1'b1; ld_base = 11'h100; dp_start = 1'b1; dp_base = 11'h000; dp_count = 12'd2;
    cyc();
    ld_start = 1'b0; dp_start = 1'b0;
    chk("arb_busy", 32'(busy), 1);
    chk("arb_load", 32'(ld_ready), 1);
    dp_start = 1'b1;
    cyc();
    dp_start = 1'b0;
    chk("arb_dp_ignored_ready", 32'(ld_ready), 1);
    chk("arb_dp_ignored_valid", 32'(dp_valid), 0);
    wr(11'h005, 32'h55);
    chk("arb_core_dataout", dataout, 0);
    ld_valid = 1'b1; ld_data = 32'h77; ld_last = 1'b1;
    cyc();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("arb_load_done", 32'(busy), 0);
    rd(11'h005, 32'hDEADBEEF);
    rd(11'h100, 32'h77);
    // reset mid-dump
    ld_start = 1'b1; ld_base = 11'h200;
    cyc();
    ld_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_data = 32'(i + 1); ld_last = (i == 4);
      cyc();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    dp_start = 1'b1; dp_base = 11'h200; dp_count = 12'd5;
    cyc();
    dp_start = 1'b0;
    cyc();
    chk("rst_dump_valid_pre", 32'(dp_valid), 1);
    chk("rst_dump_data_pre", dp_data, 32'h1);
    rst = 1'b1;
    cyc();
    chk("rst_dump_valid", 32'(dp_valid), 0);
    chk("rst_dump_busy", 32'(busy), 0);
    chk("rst_dump_dataout", dataout, 0);
    rst = 1'b0;
    rd(11'h202, 32'h3);
    rd(11'h005, 32'hDEADBEEF);
    rd(11'h7FF, 32'hB);
    cyc(2);
    chk("rd_queue_empty", 32'(exp_rd.size()), 0);
    chk("dp_queue_empty", 32'(exp_dp.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
